// File: rtl/top.sv
// RGB hue-cycling LED driver.
// Eight-bit PWM on three channels. The duty targets sweep the colour wheel in
// six segments of 256 levels. Each level lasts STEP_CYCLES clocks.
// Optional macro RGB_ACTIVE_HIGH_EN switches the outputs from active-low to
// active-high. Timing is the same in both builds.
module top #(
  parameter int STEP_CYCLES = 7812
) (
  input  logic clk,
  input  logic rst_n,
  output logic RGB_R,
  output logic RGB_G,
  output logic RGB_B
);

  localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

`ifdef RGB_ACTIVE_HIGH_EN
  localparam logic LED_ON  = 1'b1;
`else
  localparam logic LED_ON  = 1'b0;
`endif
  localparam logic LED_OFF = ~LED_ON;

  logic [7:0]        r_pwm_cnt;
  logic [STEP_W-1:0] r_step_cnt;
  logic [7:0]        r_level;
  logic [2:0]        r_seg;
  logic [7:0]        r_duty_r, r_duty_g, r_duty_b;
  logic              r_rgb_r, r_rgb_g, r_rgb_b;

  logic              w_step_tc;
  logic              w_level_tc;
  logic              w_period_end;
  logic [7:0]        w_inv_level;
  logic [7:0]        w_tgt_r, w_tgt_g, w_tgt_b;

  assign w_step_tc    = (r_step_cnt == STEP_LAST);
  assign w_level_tc   = (r_level == 8'd255);
  assign w_period_end = (r_pwm_cnt == 8'd255);
  assign w_inv_level  = 8'd255 - r_level;

  // Free-running PWM phase counter; 256-cycle period, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_cnt <= 8'd0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
    end
  end

  // Hue position: step prescaler -> level -> segment (0..5).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step_cnt <= '0;
      r_level    <= 8'd0;
      r_seg      <= 3'd0;
    end else if (w_step_tc) begin
      r_step_cnt <= '0;
      r_level    <= r_level + 8'd1;
      if (w_level_tc) begin
        r_seg <= (r_seg == 3'd5) ? 3'd0 : (r_seg + 3'd1);
      end else begin
        r_seg <= r_seg;
      end
    end else begin
      r_step_cnt <= r_step_cnt + STEP_W'(1);
    end
  end

  // Target duties from the current segment and level along the colour wheel.
  always_comb begin
    w_tgt_r = 8'd255;
    w_tgt_g = 8'd0;
    w_tgt_b = 8'd0;
    case (r_seg)
      3'd0: begin w_tgt_r = 8'd255;      w_tgt_g = r_level;     w_tgt_b = 8'd0;        end
      3'd1: begin w_tgt_r = w_inv_level; w_tgt_g = 8'd255;      w_tgt_b = 8'd0;        end
      3'd2: begin w_tgt_r = 8'd0;        w_tgt_g = 8'd255;      w_tgt_b = r_level;     end
      3'd3: begin w_tgt_r = 8'd0;        w_tgt_g = w_inv_level; w_tgt_b = 8'd255;      end
      3'd4: begin w_tgt_r = r_level;     w_tgt_g = 8'd0;        w_tgt_b = 8'd255;      end
      3'd5: begin w_tgt_r = 8'd255;      w_tgt_g = 8'd0;        w_tgt_b = w_inv_level; end
      default: begin w_tgt_r = 8'd255;   w_tgt_g = 8'd0;        w_tgt_b = 8'd0;        end
    endcase
  end

  // Latch duties only at the end of a PWM period so no pulse is ever cut short.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty_r <= 8'd255;
      r_duty_g <= 8'd0;
      r_duty_b <= 8'd0;
    end else if (w_period_end) begin
      r_duty_r <= w_tgt_r;
      r_duty_g <= w_tgt_g;
      r_duty_b <= w_tgt_b;
    end
  end

  // Registered PWM compare. Strict less-than means duty 255 still gives one off cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb_r <= LED_OFF;
      r_rgb_g <= LED_OFF;
      r_rgb_b <= LED_OFF;
    end else begin
      r_rgb_r <= (r_pwm_cnt < r_duty_r) ? LED_ON : LED_OFF;
      r_rgb_g <= (r_pwm_cnt < r_duty_g) ? LED_ON : LED_OFF;
      r_rgb_b <= (r_pwm_cnt < r_duty_b) ? LED_ON : LED_OFF;
    end
  end

  assign RGB_R = r_rgb_r;
  assign RGB_G = r_rgb_g;
  assign RGB_B = r_rgb_b;

endmodule

// File: tb/tb_top.sv
// Self-checking bench for top (RGB hue-cycling PWM).
// It uses a short STEP_CYCLES so that a whole hue cycle fits in a few thousand clocks.
// Expected waveforms come from a cycle-index model of the colour wheel.
module tb_top;

  localparam int STEP = 2;

`ifdef RGB_ACTIVE_HIGH_EN
  localparam logic ON = 1'b1;
`else
  localparam logic ON = 1'b0;
`endif
  localparam logic OFF = !ON;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic RGB_R, RGB_G, RGB_B;

  int n_cmp = 0;
  int n_fail = 0;
  int e = 0;   // rising edges since the last reset release

  typedef struct {
    int r;
    int g;
    int b;
  } vec_t;

  vec_t tbl[14];

  top #(.STEP_CYCLES(STEP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .RGB_R (RGB_R),
    .RGB_G (RGB_G),
    .RGB_B (RGB_B)
  );

  always #5 clk = ~clk;

  // The colour wheel, expressed as a total step count since reset.
  function automatic void wheel(input int steps, output int r, output int g, output int b);
    int l, s;
    l = steps % 256;
    s = (steps / 256) % 6;
    r = 255; g = 0; b = 0;
    case (s)
      0: begin r = 255;     g = l;       b = 0;       end
      1: begin r = 255 - l; g = 255;     b = 0;       end
      2: begin r = 0;       g = 255;     b = l;       end
      3: begin r = 0;       g = 255 - l; b = 255;     end
      4: begin r = l;       g = 0;       b = 255;     end
      default: begin r = 255; g = 0;     b = 255 - l; end
    endcase
  endfunction

  // Expected output bits {R,G,B} after rising edge n (n >= 1) following release.
  function automatic logic [2:0] model_out(input int n);
    int t, p, ph, r, g, b;
    t  = n - 1;
    p  = t / 256;
    ph = t % 256;
    if (p == 0) begin
      r = 255; g = 0; b = 0;
    end else begin
      // Duties latch at the last clock of the previous period.
      wheel((256 * p - 1) / STEP, r, g, b);
    end
    model_out[2] = (ph < r) ? ON : OFF;
    model_out[1] = (ph < g) ? ON : OFF;
    model_out[0] = (ph < b) ? ON : OFF;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s (edge %0d): got %0d expected %0d", nm, e, act, exp);
    end
  endtask

  // Advance one clock and compare all three outputs against the model.
  task automatic cyc(output logic [2:0] o);
    @(posedge clk);
    e++;
    @(negedge clk);
    o = {RGB_R, RGB_G, RGB_B};
    chk("cycle_rgb", int'(o), int'(model_out(e)));
  endtask

  // Measure one full PWM period of on-cycles and compare with the given counts.
  task automatic period(input string nm, input int er, input int eg, input int eb);
    logic [2:0] o;
    int cr, cg, cb;
    cr = 0; cg = 0; cb = 0;
    for (int i = 0; i < 256; i++) begin
      cyc(o);
      cr += (o[2] == ON) ? 1 : 0;
      cg += (o[1] == ON) ? 1 : 0;
      cb += (o[0] == ON) ? 1 : 0;
    end
    chk({nm, "_R"}, cr, er);
    chk({nm, "_G"}, cg, eg);
    chk({nm, "_B"}, cb, eb);
  endtask

  // Assert reset between edges, check outputs are off at once and throughout, then release.
  task automatic reset_hold(input int n);
    rst_n = 1'b0;
    #1;
    chk("reset_immediate", int'({RGB_R, RGB_G, RGB_B}), int'({OFF, OFF, OFF}));
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("reset_hold", int'({RGB_R, RGB_G, RGB_B}), int'({OFF, OFF, OFF}));
    end
    rst_n = 1'b1;
    e = 0;
  endtask

  task automatic run(input int n);
    logic [2:0] o;
    for (int i = 0; i < n; i++) begin
      cyc(o);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Periods 0..13 from release. With STEP=2 each period advances the level by 128.
    tbl[0]  = '{255,   0,   0};
    tbl[1]  = '{255, 127,   0};
    tbl[2]  = '{255, 255,   0};
    tbl[3]  = '{128, 255,   0};
    tbl[4]  = '{  0, 255,   0};
    tbl[5]  = '{  0, 255, 127};
    tbl[6]  = '{  0, 255, 255};
    tbl[7]  = '{  0, 128, 255};
    tbl[8]  = '{  0,   0, 255};
    tbl[9]  = '{127,   0, 255};
    tbl[10] = '{255,   0, 255};
    tbl[11] = '{255,   0, 128};
    tbl[12] = '{255,   0,   0};
    tbl[13] = '{255, 127,   0};

    @(negedge clk);
    reset_hold(10);

    // The table sweeps the whole wheel and its wrap back to segment 0.
    for (int i = 0; i < 14; i++) begin
      period($sformatf("period%0d", i), tbl[i].r, tbl[i].g, tbl[i].b);
    end

    // Pulse reset in the middle of segment 3. The hue must restart at segment 0.
    reset_hold(0);
    run(1800);
    reset_hold(3);
    period("after_seg3_reset", 255, 0, 0);

    // Random run lengths and random reset widths.
    for (int k = 0; k < 4; k++) begin
      run($urandom_range(1, 4000));
      reset_hold($urandom_range(1, 5));
      period($sformatf("rand_reset%0d", k), 255, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 SHALL have parameter STEP_CYCLES, default 7812: number of clk cycles per hue-level step.
REQ-002 SHALL have port clk, input, 1 bit: system clock, 12 MHz nominal, rising-edge active.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port RGB_R, output, 1 bit: red LED drive, active-low by default.
REQ-005 SHALL have port RGB_G, output, 1 bit: green LED drive, active-low by default.
REQ-006 SHALL have port RGB_B, output, 1 bit: blue LED drive, active-low by default.

Function
REQ-007 SHALL keep an 8-bit free-running pwm_cnt that increments every clk and wraps 255->0, giving a 256-cycle PWM period.
REQ-008 SHALL keep a step counter that counts 0..STEP_CYCLES-1; on terminal count it wraps to 0 and advances an 8-bit level.
REQ-009 SHALL wrap level 255->0 on a step and, in the same cycle, advance a 3-bit segment 0..5, with segment 5 wrapping to 0.
REQ-010 SHALL make one full hue cycle 6*256*STEP_CYCLES clk cycles long (11,999,232 cycles, about 1 s at 12 MHz).
REQ-011 SHALL compute target duties (R,G,B) from segment and level L as follows:
- seg0: (255, L, 0)
- seg1: (255-L, 255, 0)
- seg2: (0, 255, L)
- seg3: (0, 255-L, 255)
- seg4: (L, 0, 255)
- seg5: (255, 0, 255-L)
REQ-012 SHALL load the target duties into duty registers only in the cycle where pwm_cnt==255, so duty changes take effect at a PWM period boundary (glitch-free).
REQ-013 SHALL register each output: next output = on when pwm_cnt < duty_q, else off. Output latency is 1 clk from pwm_cnt.
REQ-014 SHALL give duty 0 -> LED on 0 of 256 cycles and duty 255 -> LED on 255 of 256 cycles. A channel is never on for the full period.
REQ-015 SHALL treat the three channels identically and update them simultaneously.

Reset
REQ-016 SHALL, while rst_n=0, asynchronously force pwm_cnt=0, step counter=0, level=0, segment=0 and duty_q=(255,0,0).
REQ-017 SHALL, while rst_n=0, drive RGB_R, RGB_G and RGB_B to the off level (1 by default).
REQ-018 SHALL resume from the REQ-016 state on the first rising clk edge after rst_n deasserts. Reset asserted mid-cycle SHALL restart the hue cycle at seg0, level 0.

Configuration
REQ-019 SHALL support macro RGB_ACTIVE_HIGH_EN.
- Undefined: outputs are active-low (on=0, off=1; reset value 1).
- Defined: outputs are active-high (on=1, off=0; reset value 0).
- All timing is identical in both builds.

Verification
REQ-020 SHALL cover reset: hold rst_n=0 for 10 cycles -> RGB_R=RGB_G=RGB_B=1 throughout.
REQ-021 SHALL cover the first period: release reset and count on-cycles over 256 cycles starting 1 clk after release -> R=255, G=0, B=0.
REQ-022 SHALL cover mid-segment: after 128*STEP_CYCLES+256 cycles, measure one full period -> R=255, G=128, B=0.
REQ-023 SHALL cover a segment boundary: after 1,999,872 cycles plus the next period boundary -> R=255, G=255, B=0 (seg1, L=0). Then after a further 1,999,872 cycles -> R=0, G=255, B=0.
REQ-024 SHALL cover wrap-around: after 11,999,232 cycles plus one period -> R=255, G=0, B=0 again. Also: pulse rst_n low for 3 cycles mid-seg3 -> outputs off immediately, then the first period after release is R=255, G=0, B=0.
REQ-025 SHALL cover the macro: with RGB_ACTIVE_HIGH_EN defined, repeat REQ-020/021 -> outputs 0 in reset and RGB_R=1 for 255 of 256 cycles.
